// File: rtl/pc_sequencer.sv
// Program counter owner at the front of fetch: sequential, branch, stall and
// debugger-driven PC selection plus run/halt/single-step control.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        dbg_halt_req_i,
  input  logic        dbg_resume_req_i,
  input  logic        dbg_step_i,
  input  logic        dbg_pc_we_i,
  input  logic [31:0] dbg_pc_wdata_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        halted_o,
  output logic        dbg_pc_ack_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  localparam state_e RESET_STATE = HALT_ON_RESET ? ST_HALTED : ST_RUN;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic        ack_q, ack_d;
  logic [31:0] seq_pc_s;

  // Next PC while executing: branch beats stall, stall beats +4.
  always_comb begin
    seq_pc_s = pc_q + 32'd4;
    if (br_taken_i) begin
      seq_pc_s = word_align(br_target_i);
    end else if (stall_i) begin
      seq_pc_s = pc_q;
    end else begin
      seq_pc_s = pc_q + 32'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        pc_d = seq_pc_s;
        // The halting cycle still fetches, so PC advances before stopping.
        if (!stall_i && (pend_q || dbg_halt_req_i)) begin
          state_d = ST_HALTED;
          pend_d  = 1'b0;
        end else if (dbg_halt_req_i) begin
          pend_d  = 1'b1;
        end else begin
          pend_d  = pend_q;
        end
      end
      ST_HALTED: begin
        pend_d = 1'b0;
        if (dbg_pc_we_i) begin
          pc_d  = word_align(dbg_pc_wdata_i);
          ack_d = 1'b1;
        end else begin
          pc_d  = pc_q;
        end
        if (dbg_resume_req_i) begin
          state_d = ST_RUN;
        end else if (dbg_step_i) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        pc_d   = seq_pc_s;
        pend_d = 1'b0;
        if (!stall_i) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = RESET_STATE;
        pc_d    = RESET_PC;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  assign pc_o          = pc_q;
  assign halted_o      = (state_q == ST_HALTED);
  assign fetch_valid_o = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stall_i;
  assign dbg_pc_ack_o  = ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with RESET_PC=0x100, starting in RUN.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        dbg_halt_req_i;
  logic        dbg_resume_req_i;
  logic        dbg_step_i;
  logic        dbg_pc_we_i;
  logic [31:0] dbg_pc_wdata_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        halted_o;
  logic        dbg_pc_ack_o;

  int checks;
  int failures;

  pc_sequencer #(
    .RESET_PC      (32'h0000_0100),
    .HALT_ON_RESET (1'b0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .br_taken_i       (br_taken_i),
    .br_target_i      (br_target_i),
    .dbg_halt_req_i   (dbg_halt_req_i),
    .dbg_resume_req_i (dbg_resume_req_i),
    .dbg_step_i       (dbg_step_i),
    .dbg_pc_we_i      (dbg_pc_we_i),
    .dbg_pc_wdata_i   (dbg_pc_wdata_i),
    .pc_o             (pc_o),
    .fetch_valid_o    (fetch_valid_o),
    .halted_o         (halted_o),
    .dbg_pc_ack_o     (dbg_pc_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        halt;
    logic        resume;
    logic        step;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_h;
    logic        exp_a;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;
    dbg_halt_req_i = 1'b0; dbg_resume_req_i = 1'b0; dbg_step_i = 1'b0;
    dbg_pc_we_i = 1'b0; dbg_pc_wdata_i = 32'h0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    // Each row: inputs for this cycle, outputs seen before the edge that consumes them.
    //            stall br   tgt           halt res  step we   wdata         exp_pc        fv   h    a
    vecs[0]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0100,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0104,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0108,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,32'h200,      1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_010C,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b1,32'h3FE,      1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0200,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_03FC,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_03FC,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,32'h40,       1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_03FC,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0040,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0040,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0040,1'b1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,32'h800,      1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0044,1'b0,1'b1,1'b0};
    vecs[12] = '{1'b1,1'b1,32'h900,      1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0044,1'b0,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,32'h1003,     32'h0000_0044,1'b0,1'b1,1'b0};
    vecs[14] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_1000,1'b0,1'b1,1'b1};
    vecs[15] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0000_1000,1'b0,1'b1,1'b0};
    vecs[16] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_1000,1'b1,1'b0,1'b0};
    vecs[17] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,1'b0,32'h0,        32'h0000_1004,1'b0,1'b1,1'b0};
    vecs[18] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_1004,1'b1,1'b0,1'b0};
    vecs[19] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_1008,1'b1,1'b0,1'b0};
    vecs[20] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,1'b1,32'h5000,     32'h0000_100C,1'b1,1'b0,1'b0};
    vecs[21] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_1010,1'b1,1'b0,1'b0};
    vecs[22] = '{1'b0,1'b1,32'hFFFF_FFF8,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_1014,1'b1,1'b0,1'b0};
    vecs[23] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFF8,1'b1,1'b0,1'b0};
    vecs[24] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFFC,1'b1,1'b0,1'b0};
    vecs[25] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_0000,1'b1,1'b0,1'b0};
    vecs[26] = '{1'b0,1'b1,32'h2000,     1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0004,1'b1,1'b0,1'b0};
    vecs[27] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,32'h3000,     32'h0000_2000,1'b0,1'b1,1'b0};
    vecs[28] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_3000,1'b0,1'b0,1'b1};
    vecs[29] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_3000,1'b1,1'b0,1'b0};
    vecs[30] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0000_3004,1'b0,1'b1,1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_pc", pc_o, 32'h0000_0100);
    check1("reset_halted", halted_o, 1'b0);
    check1("reset_ack", dbg_pc_ack_o, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall_i          = vecs[i].stall;
      br_taken_i       = vecs[i].br;
      br_target_i      = vecs[i].tgt;
      dbg_halt_req_i   = vecs[i].halt;
      dbg_resume_req_i = vecs[i].resume;
      dbg_step_i       = vecs[i].step;
      dbg_pc_we_i      = vecs[i].we;
      dbg_pc_wdata_i   = vecs[i].wdata;
      @(negedge clk);
      check32($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      check1($sformatf("v%0d_fetch_valid", i), fetch_valid_o, vecs[i].exp_fv);
      check1($sformatf("v%0d_halted", i), halted_o, vecs[i].exp_h);
      check1($sformatf("v%0d_ack", i), dbg_pc_ack_o, vecs[i].exp_a);
      @(posedge clk);
      #1;
    end

    // Async reset while a stalled single-step is in flight.
    idle_inputs();
    dbg_step_i = 1'b1;
    @(posedge clk);
    #1;
    dbg_step_i = 1'b0;
    stall_i = 1'b1;
    #2;
    check1("step_stalled_halted", halted_o, 1'b0);
    check32("step_stalled_pc", pc_o, 32'h0000_3004);
    rst = 1'b1;
    #1;
    check32("async_rst_pc", pc_o, 32'h0000_0100);
    check1("async_rst_halted", halted_o, 1'b0);
    stall_i = 1'b0;
    #1;
    check1("async_rst_run_fetch", fetch_valid_o, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset must discard a pending halt.
    dbg_halt_req_i = 1'b1;
    stall_i = 1'b1;
    @(posedge clk);
    #1;
    check1("pend_not_halted", halted_o, 1'b0);
    check32("pend_pc_held", pc_o, 32'h0000_0100);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    check32("post_rst_pc1", pc_o, 32'h0000_0104);
    check1("post_rst_run1", halted_o, 1'b0);
    @(posedge clk);
    #1;
    check32("post_rst_pc2", pc_o, 32'h0000_0108);
    check1("post_rst_run2", halted_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
